led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Sequencer and arbiter for the 8-bit LED rotator datapath. It takes three debounced button levels (left, right, mode), each from its own db_fsm instance, and turns each rising edge into a latched request. A fixed-priority arbiter serves one request per cycle. The block steps the LED pattern manually, or automatically from a prescaled 100 MHz tick, and sits between the debounce units and the board LEDs.

Parameters:
TICK_DIV, 25_000_000, CLK_100M cycles per auto step (4 Hz); legal range >= 2; prescaler width $clog2(TICK_DIV).
INIT_PATTERN, 8'h01, LED value after reset; must be nonzero.

Ports:
CLK_100M  in   1  system clock, 100 MHz
RST_N     in   1  asynchronous active-low reset
db_left   in   1  debounced level, rotate-left button
db_right  in   1  debounced level, rotate-right button
db_mode   in   1  debounced level, manual/auto toggle button
LED       out  8  registered rotator pattern
mode_auto out  1  1 = AUTO state, 0 = MANUAL state
dir_left  out  1  current rotation direction, 1 = left
grant     out  3  registered one-hot grant pulse: bit2 mode, bit1 left, bit0 right

Behaviour:
- Reset: RST_N low clears state asynchronously, regardless of clock.
  - LED = INIT_PATTERN; mode_auto = 0; dir_left = 1; grant = 0.
  - Prescaler = 0; pending flags = 0; previous-level registers = 0.
  - Reset mid-operation discards pending requests and any partial prescale count.
- Edge detect per input:
  - rise = level & ~prev_level; prev_level is registered every cycle.
  - A held level gives exactly one rise. Release and re-press gives a new rise.
- Pending latch per requester:
  - Set on the clock edge where rise = 1; cleared on the edge where the requester is granted.
  - A rise while already pending is absorbed; requests are not counted.
  - Rise and grant in the same cycle: pending ends set (the new request survives).
- Arbiter:
  - Each cycle, grant the highest-priority pending flag: mode > left > right.
  - At most one grant per cycle. Unserved requesters stay pending.
  - grant is the registered one-hot of the served requester, high for exactly 1 cycle.
- Latency: level rises in cycle N -> pending in N+1 -> grant and LED/state update visible in N+2.
- States: MANUAL, AUTO.
  - MANUAL, left grant: LED = {LED[6:0],LED[7]}; dir_left = 1.
  - MANUAL, right grant: LED = {LED[0],LED[7:1]}; dir_left = 0.
  - MANUAL, mode grant: go to AUTO; prescaler = 0; LED unchanged.
  - AUTO, prescaler: counts 0..TICK_DIV-1 and wraps to 0. At terminal count (tick), rotate LED one position in the dir_left direction.
  - AUTO, left/right grant: sets dir_left only, no immediate step.
  - AUTO, mode grant: go to MANUAL; prescaler = 0; LED holds.
- Simultaneous events in AUTO:
  - Tick + left/right grant in the same cycle: direction updates and the step uses the new direction.
  - Tick + mode grant in the same cycle: mode wins, no step.
- Invariant: LED always has exactly the popcount of INIT_PATTERN; rotation wraps bit7 <-> bit0 with no loss.
- The prescaler is frozen at 0 in MANUAL.

Decomposition:
- Package led_seq_pkg holds:
  - state enum {ST_MANUAL, ST_AUTO};
  - requester index constants REQ_RIGHT = 0, REQ_LEFT = 1, REQ_MODE = 2;
  - one-hot grant constants GNT_NONE = 3'b000, GNT_RIGHT = 3'b001, GNT_LEFT = 3'b010, GNT_MODE = 3'b100.
- Sub-module led_req_latch: one-requester rise detect plus pending flag, with inputs level and clr and output pend. Instantiated three times.
- Arbiter, FSM, prescaler and rotator stay in the top module.

Test Plan:
1. Reset, then raise db_left for 10 cycles and drop it -> grant = 3'b010 pulses for exactly 1 cycle, 2 cycles after the rise. LED goes 8'h01 -> 8'h02 once only, and dir_left = 1.
2. Raise db_left and db_right in the same cycle -> grant = 010 in one cycle, then 001 in the next cycle. LED goes 8'h01 -> 8'h02 -> 8'h01, and dir_left ends at 0.
3. Set TICK_DIV = 4, pulse db_mode -> mode_auto = 1. LED steps left every 4 cycles: 01, 02, 04, 08, … 80, 01 (wrap checked).
4. In AUTO, schedule the db_right rise so its grant lands on the tick cycle -> that step goes right (e.g. 8'h04 -> 8'h02), and later steps continue right.
5. In AUTO, schedule the db_mode grant to coincide with the tick -> mode_auto = 0 and LED unchanged on that cycle. No further steps over 20 cycles.
6. Assert RST_N = 0 asynchronously while in AUTO with left pending -> outputs return to reset values immediately without a clock edge. After release, no grant appears from the discarded request.

Source files
------------

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED sequencer
//
// Purpose: state encoding, requester indices, one-hot grant codes and the
//          8-bit rotate helper used by led_seq_ctrl.
// Ports:   none (package)

package led_seq_pkg;

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_AUTO   = 1'b1
   } state_e;

   localparam int REQ_RIGHT = 0;
   localparam int REQ_LEFT  = 1;
   localparam int REQ_MODE  = 2;

   localparam logic [2:0] GNT_NONE  = 3'b000;
   localparam logic [2:0] GNT_RIGHT = 3'b001;
   localparam logic [2:0] GNT_LEFT  = 3'b010;
   localparam logic [2:0] GNT_MODE  = 3'b100;

   // Lossless one-position rotate; bit7 and bit0 wrap into each other.
   function automatic logic [7:0] rot8(input logic [7:0] v, input logic left);
      return left ? {v[6:0], v[7]} : {v[0], v[7:1]};
   endfunction

endpackage

// File: rtl/led_req_latch.sv
// rtl/led_req_latch.sv - rise detect plus pending flag for one requester
//
// Purpose: turns a debounced level into a single latched request that is
//          held until the arbiter serves it.
// Ports:
//   clk_i    in  1  clock
//   rst_n_i  in  1  asynchronous active-low reset
//   level_i  in  1  debounced button level
//   clr_i    in  1  requester granted this cycle
//   pend_o   out 1  request pending

module led_req_latch (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic level_i,
   input  logic clr_i,
   output logic pend_o
);

   logic prev_q;
   logic pend_q;
   logic pend_d;
   logic rise;

   assign rise = level_i & ~prev_q;

   // A new rise wins over a same-cycle clear so the fresh request survives;
   // a rise while already pending just merges into the existing flag.
   assign pend_d = rise | (pend_q & ~clr_i);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         prev_q <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         prev_q <= level_i;
         pend_q <= pend_d;
      end
   end

   assign pend_o = pend_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - button sequencer, arbiter and LED rotator
//
// Purpose: latches button rises, serves one request per cycle with fixed
//          priority (mode > left > right), and steps the LED pattern either
//          manually or from a prescaled tick in AUTO.
// Ports:
//   CLK_100M   in  1  system clock
//   RST_N      in  1  asynchronous active-low reset
//   db_left    in  1  debounced rotate-left level
//   db_right   in  1  debounced rotate-right level
//   db_mode    in  1  debounced manual/auto toggle level
//   LED        out 8  registered rotator pattern
//   mode_auto  out 1  1 = AUTO, 0 = MANUAL
//   dir_left   out 1  current rotation direction, 1 = left
//   grant      out 3  registered one-hot grant pulse {mode, left, right}

module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int          TICK_DIV     = 25_000_000,
   parameter logic [7:0]  INIT_PATTERN = 8'h01
) (
   input  logic       CLK_100M,
   input  logic       RST_N,
   input  logic       db_left,
   input  logic       db_right,
   input  logic       db_mode,
   output logic [7:0] LED,
   output logic       mode_auto,
   output logic       dir_left,
   output logic [2:0] grant
);

   localparam int            PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] TC = PW'(TICK_DIV - 1);

   logic [2:0]    lvl;
   logic [2:0]    pend;
   logic [2:0]    gnt_d;
   logic [2:0]    grant_q;
   state_e        state_q, state_d;
   logic [7:0]    led_q, led_d;
   logic          dir_q, dir_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          tick;

   assign lvl[REQ_RIGHT] = db_right;
   assign lvl[REQ_LEFT]  = db_left;
   assign lvl[REQ_MODE]  = db_mode;

   for (genvar i = 0; i < 3; i++) begin : g_req
      led_req_latch u_req (
         .clk_i   (CLK_100M),
         .rst_n_i (RST_N),
         .level_i (lvl[i]),
         .clr_i   (gnt_d[i]),
         .pend_o  (pend[i])
      );
   end

   // Fixed-priority arbiter; the served flag is cleared on the same edge
   // that registers the grant and applies its effect.
   always_comb begin
      gnt_d = GNT_NONE;
      if (pend[REQ_MODE]) begin
         gnt_d = GNT_MODE;
      end else if (pend[REQ_LEFT]) begin
         gnt_d = GNT_LEFT;
      end else if (pend[REQ_RIGHT]) begin
         gnt_d = GNT_RIGHT;
      end
   end

   always_comb begin
      state_d = state_q;
      led_d   = led_q;
      dir_d   = dir_q;
      presc_d = '0;
      tick    = 1'b0;
      case (state_q)
         ST_MANUAL: begin
            if (gnt_d == GNT_MODE) begin
               state_d = ST_AUTO;
            end else if (gnt_d == GNT_LEFT) begin
               led_d = rot8(led_q, 1'b1);
               dir_d = 1'b1;
            end else if (gnt_d == GNT_RIGHT) begin
               led_d = rot8(led_q, 1'b0);
               dir_d = 1'b0;
            end
         end
         ST_AUTO: begin
            tick = (presc_q == TC);
            if (gnt_d == GNT_MODE) begin
               // Leaving AUTO suppresses any step due on this cycle.
               state_d = ST_MANUAL;
            end else begin
               if (gnt_d == GNT_LEFT) begin
                  dir_d = 1'b1;
               end else if (gnt_d == GNT_RIGHT) begin
                  dir_d = 1'b0;
               end
               presc_d = tick ? '0 : presc_q + PW'(1);
               // Step with the freshly granted direction if one lands here.
               if (tick) begin
                  led_d = rot8(led_q, dir_d);
               end
            end
         end
         default: state_d = ST_MANUAL;
      endcase
   end

   always_ff @(posedge CLK_100M or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_MANUAL;
         led_q   <= INIT_PATTERN;
         dir_q   <= 1'b1;
         presc_q <= '0;
         grant_q <= GNT_NONE;
      end else begin
         state_q <= state_d;
         led_q   <= led_d;
         dir_q   <= dir_d;
         presc_q <= presc_d;
         grant_q <= gnt_d;
      end
   end

   assign LED       = led_q;
   assign mode_auto = (state_q == ST_AUTO);
   assign dir_left  = dir_q;
   assign grant     = grant_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - self-checking bench for led_seq_ctrl

module tb_led_seq_ctrl;
   import led_seq_pkg::*;

   localparam int         TICK_DIV = 4;
   localparam logic [7:0] INIT     = 8'h01;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       db_left = 1'b0;
   logic       db_right = 1'b0;
   logic       db_mode = 1'b0;
   logic [7:0] led;
   logic       mode_auto;
   logic       dir_left;
   logic [2:0] grant;

   always #5 clk = ~clk;

   led_seq_ctrl #(.TICK_DIV(TICK_DIV), .INIT_PATTERN(INIT)) dut (
      .CLK_100M  (clk),
      .RST_N     (rst_n),
      .db_left   (db_left),
      .db_right  (db_right),
      .db_mode   (db_mode),
      .LED       (led),
      .mode_auto (mode_auto),
      .dir_left  (dir_left),
      .grant     (grant)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: LED is INIT rotated left by a signed position count,
   // requests are a set of pending bits, AUTO time is counted in edges.
   bit [2:0] m_prev, m_pend, m_grant;
   bit       m_auto, m_dir;
   int       m_pos, m_cnt;

   function automatic logic [7:0] exp_led(input int pos);
      logic [15:0] w;
      int p;
      p = ((pos % 8) + 8) % 8;
      w = {INIT, INIT} << p;
      return w[15:8];
   endfunction

   task automatic model_reset();
      m_prev = '0; m_pend = '0; m_grant = '0;
      m_auto = 1'b0; m_dir = 1'b1; m_pos = 0; m_cnt = 0;
   endtask

   // lvl order: {mode, left, right}
   task automatic model_edge(input bit [2:0] lvl);
      int served;
      served = -1;
      if (m_pend[2]) served = 2;
      else if (m_pend[1]) served = 1;
      else if (m_pend[0]) served = 0;
      m_grant = '0;
      if (served >= 0) m_grant[served] = 1'b1;
      m_pend = (m_pend & ~m_grant) | (lvl & ~m_prev);
      m_prev = lvl;
      if (served == 2) begin
         m_auto = !m_auto;
         m_cnt  = 0;
      end else begin
         if (served == 1) m_dir = 1'b1;
         if (served == 0) m_dir = 1'b0;
         if (!m_auto) begin
            if (served == 1) m_pos++;
            if (served == 0) m_pos--;
         end else if (m_cnt == TICK_DIV - 1) begin
            m_cnt = 0;
            m_pos += m_dir ? 1 : -1;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic check_outputs(input string where);
      check_eq({where, ".led"},   led,       exp_led(m_pos));
      check_eq({where, ".auto"},  mode_auto, m_auto);
      check_eq({where, ".dir"},   dir_left,  m_dir);
      check_eq({where, ".grant"}, grant,     m_grant);
      check_eq({where, ".pop"},   $countones(led), $countones(INIT));
   endtask

   task automatic cycle(input string where);
      @(posedge clk);
      if (rst_n) model_edge({db_mode, db_left, db_right});
      #1;
      check_outputs(where);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      db_left = 1'b0; db_right = 1'b0; db_mode = 1'b0;
      model_reset();
      repeat (2) cycle("rst");
      rst_n = 1'b1;
   endtask

   // Advance until the next edge would be the one before a tick edge.
   task automatic wait_pre_tick(input string where);
      int n;
      n = 0;
      while (m_cnt != TICK_DIV - 2 && n < 20) begin
         cycle(where);
         n++;
      end
      check_eq({where, ".align"}, (n < 20), 1);
   endtask

   logic [7:0] led_before;

   initial begin
      do_reset();

      // 1: single held left press gives one step
      db_left = 1'b1;
      repeat (10) cycle("t1");
      db_left = 1'b0;
      repeat (4) cycle("t1");
      check_eq("t1.final_led", led, 8'h02);

      // 2: simultaneous left+right served left then right
      do_reset();
      db_left = 1'b1; db_right = 1'b1;
      repeat (4) cycle("t2");
      db_left = 1'b0; db_right = 1'b0;
      repeat (3) cycle("t2");
      check_eq("t2.final_led", led, 8'h01);
      check_eq("t2.final_dir", dir_left, 0);

      // 3: AUTO stepping left with wrap
      do_reset();
      db_mode = 1'b1;
      cycle("t3");
      db_mode = 1'b0;
      repeat (40) cycle("t3");
      check_eq("t3.auto", mode_auto, 1);

      // 4: right grant coinciding with tick steps right
      wait_pre_tick("t4");
      led_before = led;
      db_right = 1'b1;
      cycle("t4");
      cycle("t4");
      check_eq("t4.grant", grant, GNT_RIGHT);
      check_eq("t4.step_right", led, {led_before[0], led_before[7:1]});
      db_right = 1'b0;
      repeat (12) cycle("t4");

      // 5: mode grant coinciding with tick wins, no step
      wait_pre_tick("t5");
      db_mode = 1'b1;
      cycle("t5");
      led_before = led;
      cycle("t5");
      check_eq("t5.grant", grant, GNT_MODE);
      check_eq("t5.auto", mode_auto, 0);
      check_eq("t5.led_hold", led, led_before);
      db_mode = 1'b0;
      repeat (20) cycle("t5");
      check_eq("t5.led_still", led, led_before);

      // 6: asynchronous reset with left pending in AUTO
      db_mode = 1'b1;
      cycle("t6");
      db_mode = 1'b0;
      repeat (3) cycle("t6");
      db_left = 1'b1;
      cycle("t6");
      #2;
      rst_n = 1'b0;
      db_left = 1'b0;
      model_reset();
      #1;
      check_outputs("t6.async");
      cycle("t6.rst");
      rst_n = 1'b1;
      repeat (6) cycle("t6.post");

      // Randomized levels against the model
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(5, 0) == 0) db_left  = ~db_left;
         if ($urandom_range(5, 0) == 0) db_right = ~db_right;
         if ($urandom_range(39, 0) == 0) db_mode = ~db_mode;
         cycle("rnd");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
